// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types, constants and helpers for the sram_bank storage primitive
// Contents:
//   sram_state_t : bank control state (CLEAR while zero-filling, READY for requests)
//   RW_READ/RW_WRITE : encoding of the request rw bit
//   sram_depth() : number of words addressed by an ADDR_W-bit address
package sram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } sram_state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    function automatic int sram_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// rtl/sram_rd_pipe.sv - read data/valid delay line with RD_LAT register stages
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   in_valid        : a read word is presented on in_data this cycle
//   in_data         : word read from the array
//   out_valid       : last stage carries a new result
//   out_data        : last stage data, held while out_valid is low
module sram_rd_pipe #(
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [RD_LAT-1:0] vld_q;
    logic [DATA_W-1:0] dat_q [RD_LAT];

    // Each stage only loads when the stage before it is valid, so the final
    // stage naturally holds the last delivered word between results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                dat_q[0] <= in_data;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign out_valid = vld_q[RD_LAT-1];
    assign out_data  = dat_q[RD_LAT-1];

endmodule

// File: rtl/sram_bank.sv
// rtl/sram_bank.sv - single-port SRAM bank with valid/ready requests, byte enables and post-reset clear
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   req_valid/ready : request handshake; ready only in READY state
//   rw, addr        : 1 = write, 0 = read; word address
//   din, be         : write data and per-byte write enables
//   dataout         : read result, held between results
//   rd_valid        : dataout carries a new result this cycle
//   busy            : zero-fill sequence in progress
module sram_bank
    import sram_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 4,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                rw,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   din,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   dataout,
    output logic                rd_valid,
    output logic                busy
);

    localparam int          DEPTH     = sram_depth(ADDR_W);
    localparam int          NBYTES    = DATA_W / 8;
    localparam sram_state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

    sram_state_t       state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              accept;
    logic              wr_accept;
    logic              rd_accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RST_STATE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_d = READY;
            end
        end
    end

    assign req_ready = (state_q == READY);
    assign busy      = (state_q == CLEAR);
    assign accept    = req_valid && req_ready;
    assign wr_accept = accept && (rw == RW_WRITE);
    assign rd_accept = accept && (rw == RW_READ);

    // Storage has no reset: contents change only through the clear sequence
    // or accepted writes.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_accept) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (be[k]) begin
                    mem_q[addr][8*k +: 8] <= din[8*k +: 8];
                end
            end
        end
    end

    // The first pipe stage registers mem_q[addr] on the accepting edge.
    sram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_accept),
        .in_data   (mem_q[addr]),
        .out_valid (rd_valid),
        .out_data  (dataout)
    );

endmodule

// File: tb/tb_sram_bank.sv
// tb/tb_sram_bank.sv - scoreboard bench driving RD_LAT=1 and RD_LAT=2 banks with shared stimulus
module tb_sram_bank;

    localparam int DEPTH = 16;

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        rw = 1'b0;
    logic [3:0]  addr = '0;
    logic [15:0] din = '0;
    logic [1:0]  be = '0;

    logic        req_ready1, rv1, busy1;
    logic        req_ready2, rv2, busy2;
    logic [15:0] dout1, dout2;

    logic [15:0] mdl_mem [DEPTH];
    int          clr_left = DEPTH;
    int          edge_cnt = 0;
    exp_t        sbq [2][$];
    logic [15:0] exp_last [2];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    sram_bank #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1), .CLEAR_ON_RESET(1)) u_lat1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1), .rw(rw),
        .addr(addr), .din(din), .be(be), .dataout(dout1), .rd_valid(rv1), .busy(busy1)
    );

    sram_bank #(.DATA_W(16), .ADDR_W(4), .RD_LAT(2), .CLEAR_ON_RESET(1)) u_lat2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2), .rw(rw),
        .addr(addr), .din(din), .be(be), .dataout(dout2), .rd_valid(rv2), .busy(busy2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", nm, edge_cnt, act, exp);
        end
    endtask

    // Reference behaviour at one rising edge, using the inputs that were set up before it.
    task automatic model_edge();
        exp_t e;
        if (!rst) return;
        if (clr_left > 0) begin
            mdl_mem[DEPTH - clr_left] = 16'h0000;
            clr_left--;
        end else if (req_valid) begin
            if (rw) begin
                if (be[0]) mdl_mem[addr][7:0]  = din[7:0];
                if (be[1]) mdl_mem[addr][15:8] = din[15:8];
            end else begin
                e.data = mdl_mem[addr];
                e.due  = edge_cnt;
                sbq[0].push_back(e);
                e.due  = edge_cnt + 1;
                sbq[1].push_back(e);
            end
        end
    endtask

    task automatic step(input logic v, input logic w, input int a, input logic [15:0] d,
                        input logic [1:0] b);
        req_valid = v;
        rw        = w;
        addr      = a[3:0];
        din       = d;
        be        = b;
        @(posedge clk);
        edge_cnt++;
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 0, 16'h0, 2'b00);
    endtask

    // Asserts reset mid-cycle, checks the asynchronous output values, then releases it.
    task automatic do_reset(input int hold);
        rst = 1'b0;
        #1;
        chk("rst_rd_valid_lat1", rv1, 0);
        chk("rst_rd_valid_lat2", rv2, 0);
        chk("rst_dataout_lat1", dout1, 0);
        chk("rst_dataout_lat2", dout2, 0);
        chk("rst_busy_lat1", busy1, 1);
        chk("rst_req_ready_lat2", req_ready2, 0);
        clr_left = DEPTH;
        sbq[0].delete();
        sbq[1].delete();
        exp_last[0] = 16'h0;
        exp_last[1] = 16'h0;
        idle(hold);
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic        r, bz, rdy;
            logic [15:0] d;
            exp_t        e;
            r   = (i == 0) ? rv1 : rv2;
            d   = (i == 0) ? dout1 : dout2;
            bz  = (i == 0) ? busy1 : busy2;
            rdy = (i == 0) ? req_ready1 : req_ready2;
            chk($sformatf("busy_lat%0d", i + 1), bz, (clr_left > 0) ? 1 : 0);
            chk($sformatf("req_ready_lat%0d", i + 1), rdy, (clr_left > 0) ? 0 : 1);
            while (sbq[i].size() > 0 && sbq[i][0].due < edge_cnt) begin
                e = sbq[i].pop_front();
                chk($sformatf("missing_read_lat%0d", i + 1), 0, 1);
            end
            if (r) begin
                if (sbq[i].size() == 0) begin
                    chk($sformatf("unexpected_rd_valid_lat%0d", i + 1), r, 0);
                end else begin
                    e = sbq[i].pop_front();
                    chk($sformatf("rd_latency_lat%0d", i + 1), edge_cnt, e.due);
                    chk($sformatf("rd_data_lat%0d", i + 1), d, e.data);
                    exp_last[i] = e.data;
                end
            end else begin
                chk($sformatf("dataout_hold_lat%0d", i + 1), d, exp_last[i]);
            end
        end
    end

    initial begin
        exp_last[0] = 16'h0;
        exp_last[1] = 16'h0;
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 16'hxxxx;
        #2;
        do_reset(2);

        // Reset at clear cycle 7, then a full clear with write attempts while busy.
        idle(7);
        do_reset(2);
        repeat (DEPTH) step(1'b1, 1'b1, 0, 16'hBEEF, 2'b11);

        step(1'b1, 1'b0, 5, 16'h0, 2'b00);
        step(1'b1, 1'b0, 0, 16'h0, 2'b00);

        step(1'b1, 1'b1, 3, 16'hA5C3, 2'b11);
        step(1'b1, 1'b0, 3, 16'h0, 2'b00);

        step(1'b1, 1'b1, 7, 16'hFFFF, 2'b11);
        step(1'b1, 1'b1, 7, 16'h1234, 2'b01);
        step(1'b1, 1'b0, 7, 16'h0, 2'b00);
        step(1'b1, 1'b1, 7, 16'hABCD, 2'b00);
        step(1'b1, 1'b0, 7, 16'h0, 2'b00);

        step(1'b1, 1'b1, 1, 16'h0011, 2'b11);
        step(1'b1, 1'b1, 2, 16'h0022, 2'b11);
        step(1'b1, 1'b1, 3, 16'h0033, 2'b11);
        step(1'b1, 1'b0, 1, 16'h0, 2'b00);
        step(1'b1, 1'b0, 2, 16'h0, 2'b00);
        step(1'b1, 1'b0, 3, 16'h0, 2'b00);
        idle(3);

        // Reset while a read of a nonzero word is in flight.
        step(1'b1, 1'b0, 7, 16'h0, 2'b00);
        do_reset(1);
        idle(DEPTH);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset(1);
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, DEPTH - 1), 16'($urandom), 2'($urandom));
        end
        idle(4);
        chk("drain_lat1", sbq[0].size(), 0);
        chk("drain_lat2", sbq[1].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_bank.md
# sram_bank

Parametrised single-port synchronous SRAM bank with a valid/ready request handshake, per-byte write enables, a configurable pipelined read latency and a hardware clear sequence after reset. It succeeds the fixed-size `sram` block. It sits between a bus-side requester and on-chip storage, and is the storage primitive for the team's memory subsystem testbenches and environments.

## Interface
- `DATA_W`, default 16: data width in bits; must be a multiple of 8.
- `ADDR_W`, default 4: address width; depth is `DEPTH = 2**ADDR_W` words.
- `RD_LAT`, default 1: read latency in cycles; legal values are 1 or 2.
- `CLEAR_ON_RESET`, default 1: when 1, all words are zeroed by hardware after reset.

Ports:
- `clk`  input  1  single clock; all logic on rising edge.
- `rst`  input  1  reset; asynchronous assertion, active-low (0 = reset).
- `req_valid`  input  1  request present.
- `req_ready`  output  1  bank can accept a request this cycle.
- `rw`  input  1  1 = write, 0 = read.
- `addr`  input  ADDR_W  word address.
- `din`  input  DATA_W  write data.
- `be`  input  DATA_W/8  byte enables, active on writes only.
- `dataout`  output  DATA_W  read data.
- `rd_valid`  output  1  `dataout` carries a new read result this cycle.
- `busy`  output  1  clear sequence in progress.

## Operation
- FSM states: `CLEAR`, `READY`.
- Reset state is `CLEAR` when `CLEAR_ON_RESET` = 1, otherwise `READY`.
- `CLEAR`:
  - A clear counter starts at 0.
  - Each rising edge writes all-zero to `mem[counter]` and increments the counter.
  - After writing address `DEPTH-1`, the FSM moves to `READY`.
  - Requests are not accepted while in `CLEAR`.
- `READY`: the FSM stays here until reset.
- `req_ready` = (state == `READY`). `busy` = (state == `CLEAR`). Both are decoded from state only, with no dependence on `req_valid`.
- A request is accepted on a rising edge where `req_valid && req_ready`. At most one request is accepted per cycle.
- Write: on the accepting edge, each byte `k` with `be[k]` = 1 gets `mem[addr][8k+7:8k] <= din[8k+7:8k]`. Unselected bytes keep their value. A write with `be` = 0 is a no-op. A write produces no `rd_valid`.
- Read:
  - `mem[addr]` is sampled on the accepting edge.
  - The data passes through an `RD_LAT`-stage pipeline with a valid bit per stage.
  - Reads are fully pipelined: back-to-back reads give back-to-back `rd_valid` pulses.
- Write followed by read of the same address on the next cycle returns the new data.
- `dataout` holds its last value while `rd_valid` = 0.
- Memory contents are not touched by reset itself. They are only changed by the clear sequence or by writes.

## Timing
- While `rst` = 0, outputs take these values asynchronously:
  - `rd_valid` = 0
  - `dataout` = 0
  - all pipeline valid bits = 0
  - clear counter = 0
  - `busy` = `CLEAR_ON_RESET`
  - `req_ready` = !`CLEAR_ON_RESET`
- Clear duration: after `rst` rises, `busy` stays high for exactly `DEPTH` rising edges. `req_ready` rises after the edge that writes `DEPTH-1`.
- Read accepted at edge T: `rd_valid` = 1 and `dataout` = data in the cycle after edge T+`RD_LAT`-1. That is 1 cycle after acceptance for `RD_LAT` = 1, and 2 cycles for `RD_LAT` = 2.
- Reset asserted mid-clear or mid-read:
  - In-flight reads are dropped.
  - After release, the clear sequence restarts from address 0 and runs the full `DEPTH` cycles.
- A request presented while `busy` = 1 is ignored. It has no side effect and does not have to be held by the bank.

## Structure
- Package `sram_pkg` holds:
  - `typedef enum logic {CLEAR, READY} sram_state_t`
  - constants `RW_READ` = 1'b0 and `RW_WRITE` = 1'b1
  - function `sram_depth(ADDR_W)`
- Sub-module `sram_rd_pipe` (parameters `DATA_W`, `RD_LAT`) implements the read-data/valid delay line with async active-low reset. `sram_bank` instantiates it once.

## Test plan
All scenarios use `DATA_W` = 16, `ADDR_W` = 4 unless stated.
1. Clear: release `rst` with `CLEAR_ON_RESET` = 1 → `busy` high for 16 cycles, then `req_ready` = 1. Read addr 5 → `dataout` = 0x0000, `rd_valid` one cycle later.
2. Write/read: write 0xA5C3 to addr 3 with `be` = 2'b11, then read addr 3 next cycle → `dataout` = 0xA5C3 at acceptance+`RD_LAT`.
3. Byte enables: write 0xFFFF to addr 7, then write 0x1234 with `be` = 2'b01, then read addr 7 → 0xFF34. Write with `be` = 2'b00 → still 0xFF34.
4. Pipelining with `RD_LAT` = 2: after writing 0x0011, 0x0022, 0x0033 to addr 1..3, issue reads to addr 1, 2, 3 back-to-back → `rd_valid` high 3 consecutive cycles with 0x0011, 0x0022, 0x0033, starting 2 cycles after the first accept.
5. Reset mid-clear: pull `rst` low at clear cycle 7 → `rd_valid` and `dataout` go 0 immediately. After release, `busy` lasts a full 16 cycles.
6. Request during busy: `req_valid` = 1 with write 0xBEEF to addr 0 while `busy` → not accepted. After clear, read addr 0 → 0x0000.
